// File: rtl/pc_fetch_ctrl.sv
// PC register owner and fetch sequencer: boot hold, stall/wait-state handling,
// misaligned-target and fetch-timeout faults with a software clear.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_BOOT  | PC mux held in reset for BOOT_CYCLES, then load RESET_VECTOR
// ST_FETCH | request issued at pc_out; advance on iready, hold on stall
// ST_WAIT  | memory not ready; pc_out held, counting toward timeout
// ST_FAULT | fault latched, fetch stopped until fault_clr_in
module pc_fetch_ctrl #(
  parameter int unsigned BOOT_CYCLES  = 2,
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter int unsigned WAIT_LIMIT   = 8
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] pc_mux_in,
  input  logic        misaligned_instr_in,
  input  logic        stall_in,
  input  logic        iready_in,
  input  logic        fault_clr_in,
  output logic [31:0] pc_out,
  output logic [1:0]  pc_src_out,
  output logic        pc_rst_out,
  output logic        ireq_out,
  output logic        flush_out,
  output logic        fault_out,
  output logic [1:0]  fault_cause_out,
  output logic [31:0] fault_pc_out
);

  localparam int unsigned BC_EFF = (BOOT_CYCLES < 1) ? 1 : BOOT_CYCLES;
  localparam int unsigned WL_EFF = (WAIT_LIMIT < 1) ? 1 : WAIT_LIMIT;
  localparam int unsigned BCW    = (BC_EFF < 2) ? 1 : $clog2(BC_EFF + 1);
  localparam int unsigned WCW    = $clog2(WL_EFF + 1);

  localparam logic [BCW-1:0] BOOT_LAST = BCW'(BC_EFF - 1);
  localparam logic [WCW-1:0] WAIT_MAX  = WCW'(WL_EFF);

  localparam logic [1:0] SRC_RESET = 2'b00;
  localparam logic [1:0] SRC_OPER  = 2'b11;
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_MIS  = 2'b01;
  localparam logic [1:0] CAUSE_TMO  = 2'b10;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [BCW-1:0] boot_cnt_q, boot_cnt_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [WCW-1:0] wait_cnt_inc;

  logic boot_exit;
  logic take_fetch;
  logic fault_mis;
  logic fault_tmo;
  logic fault_clr;

  logic [31:0] pc_q, pc_d;
  logic [1:0]  pc_src_q, pc_src_d;
  logic        pc_rst_q, pc_rst_d;
  logic        ireq_q, ireq_d;
  logic        flush_q, flush_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic        operating;

  // Saturating so a held WAIT can never wrap back below the limit.
  assign wait_cnt_inc = (wait_cnt_q >= WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    wait_cnt_d = wait_cnt_q;
    boot_exit  = 1'b0;
    take_fetch = 1'b0;
    fault_mis  = 1'b0;
    fault_tmo  = 1'b0;
    fault_clr  = 1'b0;
    case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) begin
          state_d    = ST_FETCH;
          boot_exit  = 1'b1;
          boot_cnt_d = '0;
          wait_cnt_d = '0;
        end else begin
          boot_cnt_d = boot_cnt_q + 1'b1;
        end
      end
      ST_FETCH: begin
        if (misaligned_instr_in) begin
          state_d   = ST_FAULT;
          fault_mis = 1'b1;
        end else if (stall_in) begin
          state_d = ST_FETCH;
        end else if (iready_in) begin
          take_fetch = 1'b1;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = WCW'(1);
          // A limit of one means the first not-ready cycle already times out.
          if (WL_EFF <= 1) begin
            state_d   = ST_FAULT;
            fault_tmo = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (misaligned_instr_in) begin
          state_d   = ST_FAULT;
          fault_mis = 1'b1;
        end else if (iready_in) begin
          state_d    = ST_FETCH;
          take_fetch = !stall_in;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_inc;
          if (wait_cnt_inc >= WAIT_MAX) begin
            state_d   = ST_FAULT;
            fault_tmo = 1'b1;
          end
        end
      end
      ST_FAULT: begin
        if (fault_clr_in) begin
          state_d    = ST_BOOT;
          boot_cnt_d = '0;
          wait_cnt_d = '0;
          fault_clr  = 1'b1;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_comb begin
    operating = (state_d == ST_FETCH) || (state_d == ST_WAIT);

    pc_d = pc_q;
    if (boot_exit) begin
      pc_d = RESET_VECTOR;
    end else if (take_fetch) begin
      pc_d = pc_mux_in;
    end

    pc_src_d = operating ? SRC_OPER : SRC_RESET;
    pc_rst_d = !operating;
    ireq_d   = operating;
    flush_d  = fault_mis || fault_tmo;
    fault_d  = (state_d == ST_FAULT);

    cause_d = cause_q;
    if (fault_mis) begin
      cause_d = CAUSE_MIS;
    end else if (fault_tmo) begin
      cause_d = CAUSE_TMO;
    end else if (fault_clr) begin
      cause_d = CAUSE_NONE;
    end

    fault_pc_d = (fault_mis || fault_tmo) ? pc_q : fault_pc_q;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pc_q       <= RESET_VECTOR;
      pc_src_q   <= SRC_RESET;
      pc_rst_q   <= 1'b1;
      ireq_q     <= 1'b0;
      flush_q    <= 1'b0;
      fault_q    <= 1'b0;
      cause_q    <= CAUSE_NONE;
      fault_pc_q <= '0;
    end else begin
      pc_q       <= pc_d;
      pc_src_q   <= pc_src_d;
      pc_rst_q   <= pc_rst_d;
      ireq_q     <= ireq_d;
      flush_q    <= flush_d;
      fault_q    <= fault_d;
      cause_q    <= cause_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign pc_out          = pc_q;
  assign pc_src_out      = pc_src_q;
  assign pc_rst_out      = pc_rst_q;
  assign ireq_out        = ireq_q;
  assign flush_out       = flush_q;
  assign fault_out       = fault_q;
  assign fault_cause_out = cause_q;
  assign fault_pc_out    = fault_pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: each driven cycle queues its expected outputs,
// a monitor pops and compares them just after the following rising edge.
module tb_pc_fetch_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic [31:0] pc_mux_in;
  logic        misaligned_instr_in = 1'b0;
  logic        stall_in = 1'b0;
  logic        iready_in = 1'b0;
  logic        fault_clr_in = 1'b0;
  logic [31:0] pc_out;
  logic [1:0]  pc_src_out;
  logic        pc_rst_out;
  logic        ireq_out;
  logic        flush_out;
  logic        fault_out;
  logic [1:0]  fault_cause_out;
  logic [31:0] fault_pc_out;

  logic        jump_en = 1'b0;
  logic [31:0] jump_tgt = 32'h0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        ireq;
    logic        flush;
    logic        fault;
    logic [1:0]  cause;
    logic [31:0] fpc;
  } exp_t;

  exp_t sb_q[$];

  // Stand-in for the PC mux: sequential +4 unless a jump target is forced.
  assign pc_mux_in = jump_en ? jump_tgt : pc_out + 32'd4;

  pc_fetch_ctrl #(
    .BOOT_CYCLES (2),
    .RESET_VECTOR(32'h0),
    .WAIT_LIMIT  (8)
  ) dut (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
    .pc_mux_in          (pc_mux_in),
    .misaligned_instr_in(misaligned_instr_in),
    .stall_in           (stall_in),
    .iready_in          (iready_in),
    .fault_clr_in       (fault_clr_in),
    .pc_out             (pc_out),
    .pc_src_out         (pc_src_out),
    .pc_rst_out         (pc_rst_out),
    .ireq_out           (ireq_out),
    .flush_out          (flush_out),
    .fault_out          (fault_out),
    .fault_cause_out    (fault_cause_out),
    .fault_pc_out       (fault_pc_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk_in) begin : monitor
    exp_t e;
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({e.tag, ".pc"},     pc_out,                   e.pc);
      check({e.tag, ".ireq"},   {31'd0, ireq_out},        {31'd0, e.ireq});
      check({e.tag, ".pc_src"}, {30'd0, pc_src_out},      e.ireq ? 32'd3 : 32'd0);
      check({e.tag, ".pc_rst"}, {31'd0, pc_rst_out},      {31'd0, !e.ireq});
      check({e.tag, ".flush"},  {31'd0, flush_out},       {31'd0, e.flush});
      check({e.tag, ".fault"},  {31'd0, fault_out},       {31'd0, e.fault});
      check({e.tag, ".cause"},  {30'd0, fault_cause_out}, {30'd0, e.cause});
      check({e.tag, ".fpc"},    fault_pc_out,             e.fpc);
    end
  end

  // Drive one cycle of inputs, queue what the outputs must be after the next edge.
  task automatic cyc(input string tag, input logic st, input logic rdy, input logic mis,
                     input logic clr, input logic [31:0] e_pc, input logic e_ireq,
                     input logic e_flush, input logic e_fault, input logic [1:0] e_cause,
                     input logic [31:0] e_fpc);
    exp_t e;
    stall_in            = st;
    iready_in           = rdy;
    misaligned_instr_in = mis;
    fault_clr_in        = clr;
    e.tag   = tag;
    e.pc    = e_pc;
    e.ireq  = e_ireq;
    e.flush = e_flush;
    e.fault = e_fault;
    e.cause = e_cause;
    e.fpc   = e_fpc;
    sb_q.push_back(e);
    @(posedge clk_in);
    #2;
  endtask

  task automatic check_rst(input string tag);
    check({tag, ".pc"},     pc_out,                   32'h0);
    check({tag, ".pc_src"}, {30'd0, pc_src_out},      32'd0);
    check({tag, ".pc_rst"}, {31'd0, pc_rst_out},      32'd1);
    check({tag, ".ireq"},   {31'd0, ireq_out},        32'd0);
    check({tag, ".flush"},  {31'd0, flush_out},       32'd0);
    check({tag, ".fault"},  {31'd0, fault_out},       32'd0);
    check({tag, ".cause"},  {30'd0, fault_cause_out}, 32'd0);
    check({tag, ".fpc"},    fault_pc_out,             32'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_in);
    #2;
    check_rst("rst_init");
    rst_n_in = 1'b1;

    // Boot: first request appears on the second edge after release.
    cyc("boot1", 0, 1, 0, 0, 32'h0, 0, 0, 0, 2'b00, 32'h0);
    cyc("boot2", 0, 1, 0, 0, 32'h0, 1, 0, 0, 2'b00, 32'h0);
    for (int i = 1; i <= 4; i++)
      cyc("seq", 0, 1, 0, 0, 32'(i * 4), 1, 0, 0, 2'b00, 32'h0);

    for (int i = 0; i < 3; i++)
      cyc("stall", 1, 1, 0, 0, 32'h10, 1, 0, 0, 2'b00, 32'h0);
    cyc("unstall", 0, 1, 0, 0, 32'h14, 1, 0, 0, 2'b00, 32'h0);

    for (int i = 0; i < 3; i++)
      cyc("wait", 0, 0, 0, 0, 32'h14, 1, 0, 0, 2'b00, 32'h0);
    cyc("wait_go", 0, 1, 0, 0, 32'h18, 1, 0, 0, 2'b00, 32'h0);

    // Ready arriving during a stall returns to FETCH without advancing.
    cyc("wait1", 0, 0, 0, 0, 32'h18, 1, 0, 0, 2'b00, 32'h0);
    cyc("wait_stall", 1, 1, 0, 0, 32'h18, 1, 0, 0, 2'b00, 32'h0);
    cyc("adv", 0, 1, 0, 0, 32'h1C, 1, 0, 0, 2'b00, 32'h0);
    cyc("clr_ign", 1, 1, 0, 1, 32'h1C, 1, 0, 0, 2'b00, 32'h0);

    // Timeout on the eighth consecutive not-ready cycle.
    for (int i = 0; i < 7; i++)
      cyc("tmo_wait", 0, 0, 0, 0, 32'h1C, 1, 0, 0, 2'b00, 32'h0);
    cyc("tmo_fault", 0, 0, 0, 0, 32'h1C, 0, 1, 1, 2'b10, 32'h1C);
    cyc("fault_hold", 0, 1, 0, 0, 32'h1C, 0, 0, 1, 2'b10, 32'h1C);
    cyc("fault_clr", 0, 0, 0, 1, 32'h1C, 0, 0, 0, 2'b00, 32'h1C);
    cyc("reboot1", 0, 1, 0, 0, 32'h1C, 0, 0, 0, 2'b00, 32'h1C);
    cyc("reboot2", 0, 1, 0, 0, 32'h0, 1, 0, 0, 2'b00, 32'h1C);
    for (int i = 1; i <= 8; i++)
      cyc("seq2", 0, 1, 0, 0, 32'(i * 4), 1, 0, 0, 2'b00, 32'h1C);

    // Misaligned target on the same cycle the timeout would fire.
    for (int i = 0; i < 7; i++)
      cyc("mis_wait", 0, 0, 0, 0, 32'h20, 1, 0, 0, 2'b00, 32'h1C);
    cyc("mis_tmo", 0, 0, 1, 0, 32'h20, 0, 1, 1, 2'b01, 32'h20);
    cyc("mis_hold", 0, 0, 0, 0, 32'h20, 0, 0, 1, 2'b01, 32'h20);

    rst_n_in = 1'b0;
    #1;
    check_rst("rst_fault");
    @(posedge clk_in);
    #2;
    rst_n_in = 1'b1;
    cyc("boot3a", 0, 1, 0, 0, 32'h0, 0, 0, 0, 2'b00, 32'h0);
    cyc("boot3b", 0, 1, 0, 0, 32'h0, 1, 0, 0, 2'b00, 32'h0);
    cyc("seq3", 0, 1, 0, 0, 32'h4, 1, 0, 0, 2'b00, 32'h0);

    // Misaligned outranks a stall in FETCH.
    cyc("mis_fetch", 1, 1, 1, 0, 32'h4, 0, 1, 1, 2'b01, 32'h4);
    cyc("fclr", 0, 1, 0, 1, 32'h4, 0, 0, 0, 2'b00, 32'h4);
    cyc("boot4a", 0, 1, 0, 0, 32'h4, 0, 0, 0, 2'b00, 32'h4);
    cyc("boot4b", 0, 1, 0, 0, 32'h0, 1, 0, 0, 2'b00, 32'h4);

    jump_en  = 1'b1;
    jump_tgt = 32'hFFFF_FFF8;
    cyc("jump", 0, 1, 0, 0, 32'hFFFF_FFF8, 1, 0, 0, 2'b00, 32'h4);
    jump_en = 1'b0;
    cyc("near_wrap", 0, 1, 0, 0, 32'hFFFF_FFFC, 1, 0, 0, 2'b00, 32'h4);
    cyc("wrap", 0, 1, 0, 0, 32'h0, 1, 0, 0, 2'b00, 32'h4);
    cyc("post_wrap", 0, 1, 0, 0, 32'h4, 1, 0, 0, 2'b00, 32'h4);
    cyc("w_a", 0, 0, 0, 0, 32'h4, 1, 0, 0, 2'b00, 32'h4);
    cyc("w_b", 0, 0, 0, 0, 32'h4, 1, 0, 0, 2'b00, 32'h4);

    rst_n_in = 1'b0;
    #1;
    check_rst("rst_wait");
    @(posedge clk_in);
    #2;
    rst_n_in = 1'b1;
    cyc("boot5a", 0, 1, 0, 0, 32'h0, 0, 0, 0, 2'b00, 32'h0);
    cyc("boot5b", 0, 1, 0, 0, 32'h0, 1, 0, 0, 2'b00, 32'h0);
    cyc("seq5", 0, 1, 0, 0, 32'h4, 1, 0, 0, 2'b00, 32'h0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
